disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving the number of clk cycles each digit is displayed; legal range is 2..2^20.
REQ-002 The block SHALL have port clk, input, width 1: the single clock, with all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port data_in, input, width 24: six hex digits to display, digit 0 in bits [3:0].
REQ-005 The block SHALL have port load, input, width 1: a request to capture data_in, sampled each clk edge.
REQ-006 The block SHALL have port disp_num, output, width 24: the registered value that the 7-segment decoder displays.
REQ-007 The block SHALL have port Scanning, output, width 3: the registered digit-select index for the 7-segment decoder.
REQ-008 The block SHALL have port frame_tick, output, width 1: a one-cycle pulse at the start of each scan frame.
REQ-009 The block SHALL have port pending, output, width 1: high while a captured value awaits commit.

Function
REQ-010 The block SHALL contain a prescaler counter that counts 0..CLK_DIV-1 and wraps to 0; its last count is the "digit tick".
REQ-011 On each digit tick, Scanning SHALL advance by 1, and from 5 it SHALL wrap to 0; values 6 and 7 SHALL never appear.
REQ-012 Each Scanning value SHALL therefore be held for exactly CLK_DIV cycles, giving a frame of 6*CLK_DIV cycles.
REQ-013 The frame boundary SHALL be the edge where Scanning goes 5->0; frame_tick SHALL be 1 for exactly the first cycle of the new frame and 0 at all other times.
REQ-014 When load=1 and the edge is not a frame boundary, data_in SHALL be captured into an internal pending register and pending SHALL go 1 on the next cycle.
REQ-015 A load while pending=1 SHALL overwrite the pending register; only the last value is kept.
REQ-016 At a frame boundary with pending=1 and load=0, disp_num SHALL take the pending register value and pending SHALL go 0.
REQ-017 At a frame boundary with load=1, disp_num SHALL take data_in directly, any older pending value SHALL be discarded, and pending SHALL go 0.
REQ-018 At a frame boundary with pending=0 and load=0, disp_num SHALL hold its value.
REQ-019 disp_num SHALL change only at frame boundaries or reset, so no frame ever shows digits from two different values.
REQ-020 load SHALL NOT affect the prescaler, Scanning, or frame_tick.
REQ-021 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.
REQ-022 Commit latency SHALL be the number of cycles from the load edge to the next frame boundary: from 1 up to 6*CLK_DIV cycles.

Reset
REQ-023 When rst_n=0, the block SHALL asynchronously force the prescaler=0, Scanning=3'b000, disp_num=24'h000000, the pending register=0, pending=0 and frame_tick=0.
REQ-024 A reset asserted mid-frame or with pending=1 SHALL discard the pending value, and no commit SHALL occur.
REQ-025 After rst_n deasserts, the first digit tick SHALL occur CLK_DIV cycles later, and the first frame_tick SHALL occur 6*CLK_DIV cycles after deassertion.
REQ-026 During reset, load SHALL be ignored.

Verification (CLK_DIV=4)
REQ-027 Scan sequence: release reset and run 48 cycles -> Scanning SHALL follow 0,1,2,3,4,5,0,1,... with each value held for 4 cycles, and frame_tick SHALL be high only at cycles 24 and 48.
REQ-028 Deferred commit: pulse load with data_in=24'h123456 at cycle 5 -> pending SHALL be 1 from cycle 6 to 23, disp_num SHALL stay 0 until cycle 24, then become 24'h123456 with pending=0.
REQ-029 Overwrite: load 24'hAAAAAA at cycle 3, then 24'h0F0F0F at cycle 10 -> at cycle 24 disp_num SHALL be 24'h0F0F0F.
REQ-030 Simultaneous load at boundary: pending holds 24'h111111 and load=1 with data_in=24'h222222 on the boundary edge -> disp_num SHALL become 24'h222222 and pending SHALL be 0.
REQ-031 Reset mid-operation: with pending=1 and Scanning=3, assert rst_n=0 asynchronously -> all outputs SHALL go 0 immediately; after release with no load, the next boundary SHALL leave disp_num at 0.
REQ-032 Idle hold: with disp_num=24'hABCDEF and no load for 3 frames -> disp_num SHALL be unchanged, and frame_tick SHALL pulse once per 24 cycles.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Six-digit 7-segment scan controller; new values commit 1..6*CLK_DIV cycles after load, at a frame boundary.
// No backpressure: load is accepted every cycle, and a newer load replaces an uncommitted one.
module disp_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] data_in,
  input  logic        load,
  output logic [23:0] disp_num,
  output logic [2:0]  Scanning,
  output logic        frame_tick,
  output logic        pending
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] presc;
  logic [23:0]   pend_dat;
  logic          digit_tick;
  logic          boundary;

  assign digit_tick = (presc == LAST);
  // Frame boundary is the digit tick that wraps the index from 5 back to 0.
  assign boundary   = digit_tick && (Scanning == 3'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      Scanning   <= 3'd0;
      frame_tick <= 1'b0;
      disp_num   <= 24'h000000;
      pend_dat   <= 24'h000000;
      pending    <= 1'b0;
    end else begin
      presc      <= digit_tick ? '0 : presc + CW'(1);
      frame_tick <= boundary;
      if (digit_tick)
        Scanning <= (Scanning == 3'd5) ? 3'd0 : Scanning + 3'd1;

      // Commit only on the boundary so a frame never mixes two values;
      // a load on the boundary edge wins over an older pending value.
      if (boundary) begin
        if (load)
          disp_num <= data_in;
        else if (pending)
          disp_num <= pend_dat;
        pending <= 1'b0;
      end else if (load) begin
        pend_dat <= data_in;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl at CLK_DIV=4: directed vector tables, async-reset sequence, randomized model check.
module tb_disp_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_in = 24'h0;
  logic        load = 1'b0;
  logic [23:0] disp_num;
  logic [2:0]  Scanning;
  logic        frame_tick;
  logic        pending;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  disp_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .disp_num(disp_num), .Scanning(Scanning), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    int          cyc;
    bit          ld;
    logic [23:0] d;
    logic [23:0] e_disp;
    bit          e_pend;
    logic [2:0]  e_scan;
    bit          e_ft;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit r, int c, bit l, logic [23:0] d, logic [23:0] ed,
                              bit ep, logic [2:0] es, bit ef);
    vec_t v;
    v.rst = r; v.cyc = c; v.ld = l; v.d = d;
    v.e_disp = ed; v.e_pend = ep; v.e_scan = es; v.e_ft = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [23:0] ed, input bit ep,
                         input logic [2:0] es, input bit ef);
    chk({tag, ".disp_num"},   disp_num, ed);
    chk({tag, ".pending"},    24'(pending), 24'(ep));
    chk({tag, ".Scanning"},   24'(Scanning), 24'(es));
    chk({tag, ".frame_tick"}, 24'(frame_tick), 24'(ef));
  endtask

  // One clock edge; inputs are sampled on it, then load returns to idle.
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    load = 1'b0;
  endtask

  // Reset for one edge, release on a falling edge: that cycle is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Reference model state: edges since reset release plus the commit rules.
  int          m_t;
  logic [23:0] m_disp, m_pval;
  bit          m_pend;

  task automatic model_reset();
    m_t = 0; m_disp = 24'h0; m_pval = 24'h0; m_pend = 0;
  endtask

  task automatic model_edge(input bit ld, input logic [23:0] d);
    m_t++;
    if (m_t % FRAME == 0) begin
      if (ld) m_disp = d;
      else if (m_pend) m_disp = m_pval;
      m_pend = 0;
    end else if (ld) begin
      m_pval = d;
      m_pend = 1;
    end
  endtask

  initial begin
    // Deferred commit and scan timing
    vt.push_back(mk(1,  0, 0, 24'h0,      24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0,  5, 1, 24'h123456, 24'h0,      0, 3'd1, 0));
    vt.push_back(mk(0,  6, 0, 24'h0,      24'h0,      1, 3'd1, 0));
    vt.push_back(mk(0, 23, 0, 24'h0,      24'h0,      1, 3'd5, 0));
    vt.push_back(mk(0, 24, 0, 24'h0,      24'h123456, 0, 3'd0, 1));
    vt.push_back(mk(0, 25, 0, 24'h0,      24'h123456, 0, 3'd0, 0));
    vt.push_back(mk(0, 28, 0, 24'h0,      24'h123456, 0, 3'd1, 0));
    vt.push_back(mk(0, 47, 0, 24'h0,      24'h123456, 0, 3'd5, 0));
    vt.push_back(mk(0, 48, 0, 24'h0,      24'h123456, 0, 3'd0, 1));
    // Overwrite of pending value
    vt.push_back(mk(1,  0, 0, 24'h0,      24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0,  3, 1, 24'hAAAAAA, 24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0,  4, 0, 24'h0,      24'h0,      1, 3'd1, 0));
    vt.push_back(mk(0, 10, 1, 24'h0F0F0F, 24'h0,      1, 3'd2, 0));
    vt.push_back(mk(0, 11, 0, 24'h0,      24'h0,      1, 3'd2, 0));
    vt.push_back(mk(0, 24, 0, 24'h0,      24'h0F0F0F, 0, 3'd0, 1));
    // Load on the boundary edge replaces pending
    vt.push_back(mk(1,  0, 0, 24'h0,      24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0, 10, 1, 24'h111111, 24'h0,      0, 3'd2, 0));
    vt.push_back(mk(0, 23, 1, 24'h222222, 24'h0,      1, 3'd5, 0));
    vt.push_back(mk(0, 24, 0, 24'h0,      24'h222222, 0, 3'd0, 1));
    vt.push_back(mk(0, 25, 0, 24'h0,      24'h222222, 0, 3'd0, 0));
    // Load on the boundary edge with nothing pending
    vt.push_back(mk(1,  0, 0, 24'h0,      24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0, 23, 1, 24'h333333, 24'h0,      0, 3'd5, 0));
    vt.push_back(mk(0, 24, 0, 24'h0,      24'h333333, 0, 3'd0, 1));
    // Idle hold across frames
    vt.push_back(mk(1,  0, 0, 24'h0,      24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0,  1, 1, 24'hABCDEF, 24'h0,      0, 3'd0, 0));
    vt.push_back(mk(0,  2, 0, 24'h0,      24'h0,      1, 3'd0, 0));
    vt.push_back(mk(0, 24, 0, 24'h0,      24'hABCDEF, 0, 3'd0, 1));
    vt.push_back(mk(0, 47, 0, 24'h0,      24'hABCDEF, 0, 3'd5, 0));
    vt.push_back(mk(0, 48, 0, 24'h0,      24'hABCDEF, 0, 3'd0, 1));
    vt.push_back(mk(0, 49, 0, 24'h0,      24'hABCDEF, 0, 3'd0, 0));
    vt.push_back(mk(0, 72, 0, 24'h0,      24'hABCDEF, 0, 3'd0, 1));
    vt.push_back(mk(0, 95, 0, 24'h0,      24'hABCDEF, 0, 3'd5, 0));
    vt.push_back(mk(0, 96, 0, 24'h0,      24'hABCDEF, 0, 3'd0, 1));

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      while (cyc < vt[i].cyc) adv();
      chk_all($sformatf("vec%0d", i), vt[i].e_disp, vt[i].e_pend, vt[i].e_scan, vt[i].e_ft);
      if (vt[i].ld) begin
        load    = 1'b1;
        data_in = vt[i].d;
      end
    end

    // Async reset with a value pending mid-frame
    do_reset();
    load = 1'b1; data_in = 24'h777777;
    while (cyc < 24) adv();
    chk_all("pre_rst_commit", 24'h777777, 0, 3'd0, 1);
    while (cyc < 30) adv();
    load = 1'b1; data_in = 24'h555555;
    while (cyc < 37) adv();
    chk_all("pre_rst", 24'h777777, 1, 3'd3, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 24'h0, 0, 3'd0, 0);
    load = 1'b1; data_in = 24'h999999;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_all("rst_ignores_load", 24'h0, 0, 3'd0, 0);
    load = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 3) adv();
    chk_all("post_rst_c3", 24'h0, 0, 3'd0, 0);
    adv();
    chk_all("post_rst_c4", 24'h0, 0, 3'd1, 0);
    while (cyc < 23) adv();
    chk_all("post_rst_c23", 24'h0, 0, 3'd5, 0);
    adv();
    chk_all("post_rst_c24", 24'h0, 0, 3'd0, 1);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      bit          ld;
      logic [23:0] d;
      chk_all("rand", m_disp, m_pend, 3'((m_t / DIV) % 6), (m_t > 0) && (m_t % FRAME == 0));
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        model_reset();
      end else begin
        if (m_t % FRAME == FRAME - 1) ld = ($urandom_range(0, 1) == 1);
        else ld = ($urandom_range(0, 9) == 0);
        d = 24'($urandom);
        load = ld;
        data_in = d;
        adv();
        model_edge(ld, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
